// File: rtl/rename_map_table.sv
// Register-rename map table: per-way source lookup with intra-group forwarding and dest remapping.
// Optional macro MAP_TABLE_CDB_BYPASS_EN makes same-cycle completions visible on lookups.
module rename_map_table #(
    parameter  int N_WAY     = 3,
    parameter  int ARCH_REGS = 32,
    parameter  int CDB_BITS  = 6,
    localparam int AW        = $clog2(ARCH_REGS),
    localparam int DW        = 3 * AW + 1,
    localparam int PW        = CDB_BITS + 1
) (
    input  logic                           clock,
    input  logic                           reset,
    // per way, MSB to LSB: {valid, src1, src2, dest}
    input  logic [N_WAY-1:0][DW-1:0]       dis_packet,
    input  logic [N_WAY-1:0][CDB_BITS-1:0] pr_freelist,
    input  logic [N_WAY-1:0][CDB_BITS-1:0] pr_reg_complete,
    // per way: {pr, ready}
    output logic [N_WAY-1:0][PW-1:0]       pr_packet_out1,
    output logic [N_WAY-1:0][PW-1:0]       pr_packet_out2
);

    logic [CDB_BITS-1:0]       prQ [ARCH_REGS];
    logic [CDB_BITS-1:0]       prD [ARCH_REGS];
    logic [ARCH_REGS-1:0]      readyQ;
    logic [ARCH_REGS-1:0]      readyD;

    logic [N_WAY-1:0]          wayValid;
    logic [N_WAY-1:0][AW-1:0]  waySrc1;
    logic [N_WAY-1:0][AW-1:0]  waySrc2;
    logic [N_WAY-1:0][AW-1:0]  wayDest;

    logic [AW-1:0]             src;
    logic [PW-1:0]             res;

    always_comb begin
        wayValid = '0;
        waySrc1  = '0;
        waySrc2  = '0;
        wayDest  = '0;
        for (int k = 0; k < N_WAY; k++) begin
            wayValid[k] = dis_packet[k][DW-1];
            waySrc1[k]  = dis_packet[k][3*AW-1:2*AW];
            waySrc2[k]  = dis_packet[k][2*AW-1:AW];
            wayDest[k]  = dis_packet[k][AW-1:0];
        end
    end

    // A younger way sees an older way's new mapping; the youngest matching older way wins,
    // and that forwarded PR is never ready in the same cycle it was allocated.
    always_comb begin
        pr_packet_out1 = '0;
        pr_packet_out2 = '0;
        src            = '0;
        res            = '0;
        for (int k = 0; k < N_WAY; k++) begin
            for (int s = 0; s < 2; s++) begin
                src = (s == 0) ? waySrc1[k] : waySrc2[k];
                res = {prQ[src], readyQ[src]};
`ifdef MAP_TABLE_CDB_BYPASS_EN
                for (int c = 0; c < N_WAY; c++) begin
                    if (pr_reg_complete[c] != '0 && pr_reg_complete[c] == res[PW-1:1]) begin
                        res[0] = 1'b1;
                    end
                end
`endif
                for (int j = 0; j < k; j++) begin
                    if (wayValid[j] && wayDest[j] == src && wayDest[j] != '0) begin
                        res = {pr_freelist[j], 1'b0};
                    end
                end
                if (src == '0) begin
                    res = {{CDB_BITS{1'b0}}, 1'b1};
                end
                if (!wayValid[k]) begin
                    res = '0;
                end
                if (s == 0) begin
                    pr_packet_out1[k] = res;
                end else begin
                    pr_packet_out2[k] = res;
                end
            end
        end
    end

    // Completions are applied first so a same-cycle rename of the entry overrides them.
    always_comb begin
        prD    = prQ;
        readyD = readyQ;
        for (int e = 0; e < ARCH_REGS; e++) begin
            for (int c = 0; c < N_WAY; c++) begin
                if (pr_reg_complete[c] != '0 && prQ[e] == pr_reg_complete[c]) begin
                    readyD[e] = 1'b1;
                end
            end
        end
        for (int k = 0; k < N_WAY; k++) begin
            if (wayValid[k] && wayDest[k] != '0) begin
                prD[wayDest[k]]    = pr_freelist[k];
                readyD[wayDest[k]] = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                prQ[i] <= CDB_BITS'(i);
            end
            readyQ <= '1;
        end else begin
            prQ    <= prD;
            readyQ <= readyD;
        end
    end

endmodule

// File: tb/tb_rename_map_table.sv
// Self-checking bench for rename_map_table: directed scenarios plus randomized traffic
// checked against an array-based model of the rename rules.
module tb_rename_map_table;

    localparam int N_WAY     = 3;
    localparam int ARCH_REGS = 32;
    localparam int CDB_BITS  = 6;
    localparam int AW        = $clog2(ARCH_REGS);

    logic clock = 1'b0;
    logic reset;
    logic [N_WAY-1:0][3*AW:0]       disPacket;
    logic [N_WAY-1:0][CDB_BITS-1:0] prFreelist;
    logic [N_WAY-1:0][CDB_BITS-1:0] prRegComplete;
    logic [N_WAY-1:0][CDB_BITS:0]   out1;
    logic [N_WAY-1:0][CDB_BITS:0]   out2;

    int compared   = 0;
    int mismatched = 0;

    int vValid [N_WAY];
    int vSrc1  [N_WAY];
    int vSrc2  [N_WAY];
    int vDest  [N_WAY];
    int vFl    [N_WAY];
    int vCmp   [N_WAY];

    int mPr  [ARCH_REGS];
    int mRdy [ARCH_REGS];

`ifdef MAP_TABLE_CDB_BYPASS_EN
    bit bypassEn = 1'b1;
`else
    bit bypassEn = 1'b0;
`endif

    rename_map_table #(
        .N_WAY(N_WAY),
        .ARCH_REGS(ARCH_REGS),
        .CDB_BITS(CDB_BITS)
    ) dut (
        .clock(clock),
        .reset(reset),
        .dis_packet(disPacket),
        .pr_freelist(prFreelist),
        .pr_reg_complete(prRegComplete),
        .pr_packet_out1(out1),
        .pr_packet_out2(out2)
    );

    always #5 clock = ~clock;

    function automatic logic [CDB_BITS:0] pk(int pr, int rdy);
        return {CDB_BITS'(pr), rdy[0]};
    endfunction

    task automatic drive();
        for (int k = 0; k < N_WAY; k++) begin
            disPacket[k]     = {vValid[k][0], AW'(vSrc1[k]), AW'(vSrc2[k]), AW'(vDest[k])};
            prFreelist[k]    = CDB_BITS'(vFl[k]);
            prRegComplete[k] = CDB_BITS'(vCmp[k]);
        end
    endtask

    task automatic clearAll();
        for (int k = 0; k < N_WAY; k++) begin
            vValid[k] = 0; vSrc1[k] = 0; vSrc2[k] = 0;
            vDest[k]  = 0; vFl[k]   = 0; vCmp[k]  = 0;
        end
    endtask

    task automatic setWay(int k, int s1, int s2, int d, int fl);
        vValid[k] = 1; vSrc1[k] = s1; vSrc2[k] = s2; vDest[k] = d; vFl[k] = fl;
    endtask

    // Model: what a source should read, scanning older ways from youngest to oldest first.
    function automatic logic [CDB_BITS:0] modelLookup(int k, int src);
        int pr;
        int rdy;
        if (vValid[k] == 0) return '0;
        if (src == 0) return pk(0, 1);
        for (int j = k - 1; j >= 0; j--) begin
            if (vValid[j] != 0 && vDest[j] == src) return pk(vFl[j], 0);
        end
        pr  = mPr[src];
        rdy = mRdy[src];
        if (bypassEn && pr != 0) begin
            for (int c = 0; c < N_WAY; c++) if (vCmp[c] == pr) rdy = 1;
        end
        return pk(pr, rdy);
    endfunction

    task automatic modelCommit();
        for (int e = 0; e < ARCH_REGS; e++) begin
            for (int c = 0; c < N_WAY; c++) begin
                if (vCmp[c] != 0 && mPr[e] == vCmp[c]) mRdy[e] = 1;
            end
        end
        for (int k = 0; k < N_WAY; k++) begin
            if (vValid[k] != 0 && vDest[k] != 0) begin
                mPr[vDest[k]]  = vFl[k];
                mRdy[vDest[k]] = 0;
            end
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < ARCH_REGS; i++) begin
            mPr[i]  = i;
            mRdy[i] = 1;
        end
    endtask

    task automatic nextCycle();
        modelCommit();
        @(negedge clock);
    endtask

    task automatic test_reset();
        logic [CDB_BITS:0] e1 [N_WAY];
        logic [CDB_BITS:0] e2 [N_WAY];
        reset = 1'b1;
        clearAll();
        drive();
        modelReset();
        #2;
        for (int k = 0; k < N_WAY; k++) begin
            compared++;
            if (out1[k] !== '0 || out2[k] !== '0) begin
                mismatched++;
                $display("[TB] FAIL reset_idle way%0d: got %h/%h expected 0/0", k, out1[k], out2[k]);
            end
        end
        setWay(0, 5, 31, 0, 1);
        setWay(1, 17, 0, 0, 1);
        setWay(2, 30, 1, 0, 1);
        drive();
        #1;
        e1 = '{pk(5, 1), pk(17, 1), pk(30, 1)};
        e2 = '{pk(31, 1), pk(0, 1), pk(1, 1)};
        for (int k = 0; k < N_WAY; k++) begin
            compared++;
            if (out1[k] !== e1[k]) begin
                mismatched++;
                $display("[TB] FAIL reset_identity way%0d src1: got %h expected %h", k, out1[k], e1[k]);
            end
            compared++;
            if (out2[k] !== e2[k]) begin
                mismatched++;
                $display("[TB] FAIL reset_identity way%0d src2: got %h expected %h", k, out2[k], e2[k]);
            end
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_basic_lookup();
        logic [CDB_BITS:0] e1 [N_WAY];
        logic [CDB_BITS:0] e2 [N_WAY];
        clearAll();
        setWay(0, 0, 1, 2, 33);
        setWay(1, 3, 4, 5, 34);
        setWay(2, 6, 7, 8, 35);
        drive();
        #2;
        e1 = '{pk(0, 1), pk(3, 1), pk(6, 1)};
        e2 = '{pk(1, 1), pk(4, 1), pk(7, 1)};
        for (int k = 0; k < N_WAY; k++) begin
            compared++;
            if (out1[k] !== e1[k]) begin
                mismatched++;
                $display("[TB] FAIL basic way%0d src1: got %h expected %h", k, out1[k], e1[k]);
            end
            compared++;
            if (out2[k] !== e2[k]) begin
                mismatched++;
                $display("[TB] FAIL basic way%0d src2: got %h expected %h", k, out2[k], e2[k]);
            end
        end
        nextCycle();
    endtask

    task automatic test_intra_group();
        logic [CDB_BITS:0] e1 [N_WAY];
        logic [CDB_BITS:0] e2 [N_WAY];
        clearAll();
        setWay(0, 1, 2, 3, 36);
        setWay(1, 3, 4, 5, 37);
        setWay(2, 7, 5, 8, 38);
        drive();
        #2;
        e1 = '{pk(1, 1), pk(36, 0), pk(7, 1)};
        e2 = '{pk(33, 0), pk(4, 1), pk(37, 0)};
        for (int k = 0; k < N_WAY; k++) begin
            compared++;
            if (out1[k] !== e1[k]) begin
                mismatched++;
                $display("[TB] FAIL intra way%0d src1: got %h expected %h", k, out1[k], e1[k]);
            end
            compared++;
            if (out2[k] !== e2[k]) begin
                mismatched++;
                $display("[TB] FAIL intra way%0d src2: got %h expected %h", k, out2[k], e2[k]);
            end
        end
        nextCycle();
    endtask

    task automatic test_completion();
        logic [CDB_BITS:0] e1 [N_WAY];
        logic [CDB_BITS:0] e2 [N_WAY];
        clearAll();
        setWay(0, 5, 6, 8, 39);
        setWay(1, 2, 3, 4, 43);
        setWay(2, 6, 7, 0, 44);
        vCmp[0] = 33;
        vCmp[1] = 34;
        drive();
        #2;
        e1 = '{pk(37, 0), pk(33, bypassEn ? 1 : 0), pk(6, 1)};
        e2 = '{pk(6, 1), pk(36, 0), pk(7, 1)};
        for (int k = 0; k < N_WAY; k++) begin
            compared++;
            if (out1[k] !== e1[k]) begin
                mismatched++;
                $display("[TB] FAIL completion way%0d src1: got %h expected %h", k, out1[k], e1[k]);
            end
            compared++;
            if (out2[k] !== e2[k]) begin
                mismatched++;
                $display("[TB] FAIL completion way%0d src2: got %h expected %h", k, out2[k], e2[k]);
            end
        end
        nextCycle();
    endtask

    task automatic test_idle_ways();
        logic [CDB_BITS:0] e1 [N_WAY];
        logic [CDB_BITS:0] e2 [N_WAY];
        clearAll();
        vSrc1[0] = 2; vSrc2[1] = 3; vDest[2] = 9; vFl[2] = 50;
        drive();
        #2;
        for (int k = 0; k < N_WAY; k++) begin
            compared++;
            if (out1[k] !== '0 || out2[k] !== '0) begin
                mismatched++;
                $display("[TB] FAIL idle way%0d: got %h/%h expected 0/0", k, out1[k], out2[k]);
            end
        end
        nextCycle();
        clearAll();
        setWay(0, 0, 2, 0, 1);
        drive();
        #2;
        e1 = '{pk(0, 1), '0, '0};
        e2 = '{pk(33, 1), '0, '0};
        for (int k = 0; k < N_WAY; k++) begin
            compared++;
            if (out1[k] !== e1[k]) begin
                mismatched++;
                $display("[TB] FAIL after_idle way%0d src1: got %h expected %h", k, out1[k], e1[k]);
            end
            compared++;
            if (out2[k] !== e2[k]) begin
                mismatched++;
                $display("[TB] FAIL after_idle way%0d src2: got %h expected %h", k, out2[k], e2[k]);
            end
        end
        nextCycle();
    endtask

    task automatic test_same_dest();
        logic [CDB_BITS:0] e1 [N_WAY];
        logic [CDB_BITS:0] e2 [N_WAY];
        clearAll();
        setWay(0, 1, 2, 9, 40);
        setWay(1, 9, 0, 0, 41);
        setWay(2, 9, 10, 9, 42);
        drive();
        #2;
        e1 = '{pk(1, 1), pk(40, 0), pk(40, 0)};
        e2 = '{pk(33, 1), pk(0, 1), pk(10, 1)};
        for (int k = 0; k < N_WAY; k++) begin
            compared++;
            if (out1[k] !== e1[k]) begin
                mismatched++;
                $display("[TB] FAIL same_dest way%0d src1: got %h expected %h", k, out1[k], e1[k]);
            end
            compared++;
            if (out2[k] !== e2[k]) begin
                mismatched++;
                $display("[TB] FAIL same_dest way%0d src2: got %h expected %h", k, out2[k], e2[k]);
            end
        end
        nextCycle();
        clearAll();
        setWay(0, 9, 8, 0, 1);
        drive();
        #2;
        compared++;
        if (out1[0] !== pk(42, 0)) begin
            mismatched++;
            $display("[TB] FAIL same_dest_winner: got %h expected %h", out1[0], pk(42, 0));
        end
        compared++;
        if (out2[0] !== pk(39, 0)) begin
            mismatched++;
            $display("[TB] FAIL same_dest_other: got %h expected %h", out2[0], pk(39, 0));
        end
        nextCycle();
    endtask

    task automatic randomizeWays();
        for (int k = 0; k < N_WAY; k++) begin
            vValid[k] = ($urandom_range(0, 3) != 0) ? 1 : 0;
            vSrc1[k]  = $urandom_range(0, ARCH_REGS - 1);
            vSrc2[k]  = $urandom_range(0, ARCH_REGS - 1);
            vDest[k]  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 12);
            vFl[k]    = $urandom_range(1, (1 << CDB_BITS) - 1);
            vCmp[k]   = ($urandom_range(0, 2) == 0) ? 0 : mPr[$urandom_range(0, ARCH_REGS - 1)];
        end
        if ($urandom_range(0, 3) == 0 && vValid[0] != 0) vSrc1[N_WAY-1] = vDest[0];
    endtask

    task automatic test_random();
        logic [CDB_BITS:0] exp1;
        logic [CDB_BITS:0] exp2;
        for (int n = 0; n < 400; n++) begin
            randomizeWays();
            drive();
            #2;
            for (int k = 0; k < N_WAY; k++) begin
                exp1 = modelLookup(k, vSrc1[k]);
                exp2 = modelLookup(k, vSrc2[k]);
                compared++;
                if (out1[k] !== exp1) begin
                    mismatched++;
                    $display("[TB] FAIL random cyc%0d way%0d src1=%0d: got %h expected %h",
                             n, k, vSrc1[k], out1[k], exp1);
                end
                compared++;
                if (out2[k] !== exp2) begin
                    mismatched++;
                    $display("[TB] FAIL random cyc%0d way%0d src2=%0d: got %h expected %h",
                             n, k, vSrc2[k], out2[k], exp2);
                end
            end
            nextCycle();
        end
    endtask

    // Reset lands mid-cycle: lookups must switch to identity immediately and stay there across an edge.
    task automatic test_reset_midstream();
        logic [CDB_BITS:0] exp1;
        logic [CDB_BITS:0] exp2;
        for (int phase = 0; phase < 3; phase++) begin
            randomizeWays();
            drive();
            if (phase == 0) begin
                #2;
                reset = 1'b1;
                modelReset();
            end
            #1;
            for (int k = 0; k < N_WAY; k++) begin
                exp1 = modelLookup(k, vSrc1[k]);
                exp2 = modelLookup(k, vSrc2[k]);
                compared++;
                if (out1[k] !== exp1) begin
                    mismatched++;
                    $display("[TB] FAIL midreset ph%0d way%0d src1=%0d: got %h expected %h",
                             phase, k, vSrc1[k], out1[k], exp1);
                end
                compared++;
                if (out2[k] !== exp2) begin
                    mismatched++;
                    $display("[TB] FAIL midreset ph%0d way%0d src2=%0d: got %h expected %h",
                             phase, k, vSrc2[k], out2[k], exp2);
                end
            end
            if (phase == 0) begin
                @(negedge clock);
            end else if (phase == 1) begin
                reset = 1'b0;
                nextCycle();
            end else begin
                nextCycle();
            end
        end
    endtask

    initial begin
        $display("[TB] rename_map_table bench start (bypass=%0d)", bypassEn);
        test_reset();
        test_basic_lookup();
        test_intra_group();
        test_completion();
        test_idle_ways();
        test_same_dest();
        test_random();
        test_reset_midstream();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
